// File: rtl/ahb_mtx_pkg.sv
// Shared AHB encodings and defaults for the DMA bus matrix.
// Used by the input stages and the output-port arbiters.
package ahb_mtx_pkg;

    localparam int ADDR_W_DEF = 32;
    localparam int PROT_W_DEF = 4;

    typedef enum logic [1:0] {
        TRANS_IDLE   = 2'b00,
        TRANS_BUSY   = 2'b01,
        TRANS_NONSEQ = 2'b10,
        TRANS_SEQ    = 2'b11
    } htrans_e;

    typedef enum logic [2:0] {
        BURST_SINGLE = 3'b000,
        BURST_INCR   = 3'b001,
        BURST_WRAP4  = 3'b010,
        BURST_INCR4  = 3'b011,
        BURST_WRAP8  = 3'b100,
        BURST_INCR8  = 3'b101,
        BURST_WRAP16 = 3'b110,
        BURST_INCR16 = 3'b111
    } hburst_e;

    typedef enum logic {
        RESP_OKAY  = 1'b0,
        RESP_ERROR = 1'b1
    } hresp_e;

endpackage

// File: rtl/ahb_instg_hold_reg.sv
// Hold-register bank for a stalled address phase.
// Replays as NONSEQ; a held SEQ beat is replayed as an INCR burst.
module ahb_instg_hold_reg
    import ahb_mtx_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int PROT_W = PROT_W_DEF
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_cap,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [1:0]        i_trans,
    input  logic              i_write,
    input  logic [2:0]        i_size,
    input  logic [2:0]        i_burst,
    input  logic [PROT_W-1:0] i_prot,
    input  logic              i_lock,
    output logic [ADDR_W-1:0] o_addr,
    output logic [1:0]        o_trans,
    output logic              o_write,
    output logic [2:0]        o_size,
    output logic [2:0]        o_burst,
    output logic [PROT_W-1:0] o_prot,
    output logic              o_lock
);

    logic [ADDR_W-1:0] r_addr;
    logic [1:0]        r_trans;
    logic              r_write;
    logic [2:0]        r_size;
    logic [2:0]        r_burst;
    logic [PROT_W-1:0] r_prot;
    logic              r_lock;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_addr  <= '0;
            r_trans <= '0;
            r_write <= 1'b0;
            r_size  <= '0;
            r_burst <= '0;
            r_prot  <= '0;
            r_lock  <= 1'b0;
        end else if (i_cap) begin
            r_addr  <= i_addr;
            r_trans <= i_trans;
            r_write <= i_write;
            r_size  <= i_size;
            r_burst <= i_burst;
            r_prot  <= i_prot;
            r_lock  <= i_lock;
        end
    end

    // Arbitration broke the burst, so the replayed beat starts a fresh one
    always_comb begin
        o_addr  = r_addr;
        o_trans = TRANS_NONSEQ;
        o_write = r_write;
        o_size  = r_size;
        o_burst = (r_trans == TRANS_SEQ) ? BURST_INCR : r_burst;
        o_prot  = r_prot;
        o_lock  = r_lock;
    end

endmodule

// File: rtl/ahb_instg_dma.sv
// Per-master AHB input stage of the DMA bus matrix.
// Optional: AHB_INSTG_ERR_FLUSH_EN drops a held transfer on slave ERROR.
module ahb_instg_dma
    import ahb_mtx_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int PROT_W = PROT_W_DEF
) (
    input  logic              HCLK,
    input  logic              HRESET,
    input  logic              HSELS,
    input  logic [ADDR_W-1:0] HADDRS,
    input  logic [1:0]        HTRANSS,
    input  logic              HWRITES,
    input  logic [2:0]        HSIZES,
    input  logic [2:0]        HBURSTS,
    input  logic [PROT_W-1:0] HPROTS,
    input  logic              HMASTLOCKS,
    input  logic              HREADYS,
    output logic              HREADYOUTS,
    output logic              HRESPS,
    input  logic              active_trans,
    input  logic              HREADYM,
    input  logic              HRESPM,
    output logic              req,
    output logic              HSELM,
    output logic [ADDR_W-1:0] HADDRM,
    output logic [1:0]        HTRANSM,
    output logic              HWRITEM,
    output logic [2:0]        HSIZEM,
    output logic [2:0]        HBURSTM,
    output logic [PROT_W-1:0] HPROTM,
    output logic              HMASTLOCKM
);

    logic              r_pend;
    logic              r_data_phase;
    logic              w_addr_valid;
    logic              w_accept;
    logic              w_capture;
    logic              w_flush;
    logic [ADDR_W-1:0] w_h_addr;
    logic [1:0]        w_h_trans;
    logic              w_h_write;
    logic [2:0]        w_h_size;
    logic [2:0]        w_h_burst;
    logic [PROT_W-1:0] w_h_prot;
    logic              w_h_lock;

    assign w_addr_valid = HSELS & HREADYS & HTRANSS[1];
    assign w_accept     = active_trans & HREADYM & (r_pend | w_addr_valid);
    assign w_capture    = w_addr_valid & ~w_accept & ~r_pend;

`ifdef AHB_INSTG_ERR_FLUSH_EN
    assign w_flush = r_pend & r_data_phase & ~HREADYM & HRESPM;
`else
    assign w_flush = 1'b0;
`endif

    ahb_instg_hold_reg #(
        .ADDR_W (ADDR_W),
        .PROT_W (PROT_W)
    ) u_hold (
        .i_clk   (HCLK),
        .i_rst   (HRESET),
        .i_cap   (w_capture),
        .i_addr  (HADDRS),
        .i_trans (HTRANSS),
        .i_write (HWRITES),
        .i_size  (HSIZES),
        .i_burst (HBURSTS),
        .i_prot  (HPROTS),
        .i_lock  (HMASTLOCKS),
        .o_addr  (w_h_addr),
        .o_trans (w_h_trans),
        .o_write (w_h_write),
        .o_size  (w_h_size),
        .o_burst (w_h_burst),
        .o_prot  (w_h_prot),
        .o_lock  (w_h_lock)
    );

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            r_pend <= 1'b0;
        end else if (w_capture) begin
            r_pend <= 1'b1;
        end else if (r_pend & (w_accept | w_flush)) begin
            r_pend <= 1'b0;
        end
    end

    // Data phase only advances when the slave side completes a cycle
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            r_data_phase <= 1'b0;
        end else if (HREADYM) begin
            r_data_phase <= w_accept;
        end
    end

    always_comb begin
        HSELM      = r_pend | HSELS;
        HADDRM     = HADDRS;
        HTRANSM    = HTRANSS;
        HWRITEM    = HWRITES;
        HSIZEM     = HSIZES;
        HBURSTM    = HBURSTS;
        HPROTM     = HPROTS;
        HMASTLOCKM = HMASTLOCKS;
        if (r_pend) begin
            HADDRM     = w_h_addr;
            HTRANSM    = w_h_trans;
            HWRITEM    = w_h_write;
            HSIZEM     = w_h_size;
            HBURSTM    = w_h_burst;
            HPROTM     = w_h_prot;
            HMASTLOCKM = w_h_lock;
        end
    end

    assign req        = r_pend | w_addr_valid;
    assign HREADYOUTS = r_data_phase ? HREADYM : ~r_pend;
    assign HRESPS     = r_data_phase ? HRESPM : RESP_OKAY;

endmodule

// File: tb/tb_ahb_instg_dma.sv
// Scenario bench for ahb_instg_dma; address phases and responses are
// queued as expectations when driven and popped when the DUT presents them.
module tb_ahb_instg_dma;

    localparam int AW = 32;
    localparam int PW = 4;

    typedef struct {
        logic [AW-1:0] addr;
        logic [1:0]    trans;
        logic [2:0]    burst;
        logic          write;
    } exp_t;

    logic          HCLK;
    logic          HRESET;
    logic          HSELS;
    logic [AW-1:0] HADDRS;
    logic [1:0]    HTRANSS;
    logic          HWRITES;
    logic [2:0]    HSIZES;
    logic [2:0]    HBURSTS;
    logic [PW-1:0] HPROTS;
    logic          HMASTLOCKS;
    logic          HREADYS;
    logic          HREADYOUTS;
    logic          HRESPS;
    logic          active_trans;
    logic          HREADYM;
    logic          HRESPM;
    logic          req;
    logic          HSELM;
    logic [AW-1:0] HADDRM;
    logic [1:0]    HTRANSM;
    logic          HWRITEM;
    logic [2:0]    HSIZEM;
    logic [2:0]    HBURSTM;
    logic [PW-1:0] HPROTM;
    logic          HMASTLOCKM;

    exp_t       sb_q[$];
    logic [1:0] rsp_q[$];
    int         n_vec;
    int         n_err;

    ahb_instg_dma #(
        .ADDR_W (AW),
        .PROT_W (PW)
    ) dut (
        .HCLK         (HCLK),
        .HRESET       (HRESET),
        .HSELS        (HSELS),
        .HADDRS       (HADDRS),
        .HTRANSS      (HTRANSS),
        .HWRITES      (HWRITES),
        .HSIZES       (HSIZES),
        .HBURSTS      (HBURSTS),
        .HPROTS       (HPROTS),
        .HMASTLOCKS   (HMASTLOCKS),
        .HREADYS      (HREADYS),
        .HREADYOUTS   (HREADYOUTS),
        .HRESPS       (HRESPS),
        .active_trans (active_trans),
        .HREADYM      (HREADYM),
        .HRESPM       (HRESPM),
        .req          (req),
        .HSELM        (HSELM),
        .HADDRM       (HADDRM),
        .HTRANSM      (HTRANSM),
        .HWRITEM      (HWRITEM),
        .HSIZEM       (HSIZEM),
        .HBURSTM      (HBURSTM),
        .HPROTM       (HPROTM),
        .HMASTLOCKM   (HMASTLOCKM)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    task automatic step();
        @(posedge HCLK);
        #1;
    endtask

    task automatic master_idle();
        HSELS      = 1'b0;
        HADDRS     = '0;
        HTRANSS    = 2'b00;
        HWRITES    = 1'b0;
        HSIZES     = 3'd2;
        HBURSTS    = 3'b000;
        HPROTS     = 4'h3;
        HMASTLOCKS = 1'b0;
        HREADYS    = 1'b1;
    endtask

    task automatic master_drive(input logic [AW-1:0] a, input logic [1:0] t,
                                input logic [2:0] b, input logic w);
        HSELS   = 1'b1;
        HADDRS  = a;
        HTRANSS = t;
        HBURSTS = b;
        HWRITES = w;
        HREADYS = 1'b1;
    endtask

    task automatic push_exp(input logic [AW-1:0] a, input logic [1:0] t,
                            input logic [2:0] b, input logic w);
        exp_t e;
        e.addr  = a;
        e.trans = t;
        e.burst = b;
        e.write = w;
        sb_q.push_back(e);
    endtask

    task automatic test_reset();
        exp_t e;
        master_idle();
        active_trans = 1'b0;
        HREADYM = 1'b1;
        HRESPM = 1'b0;
        HRESET = 1'b1;
        step();
        step();
        HRESET = 1'b0;
        #1;
        n_vec++;
        if (HREADYOUTS !== 1'b1) begin
            n_err++;
            $display("FAIL reset_hreadyout got=%b exp=1", HREADYOUTS);
        end
        n_vec++;
        if (HRESPS !== 1'b0) begin
            n_err++;
            $display("FAIL reset_hresp got=%b exp=0", HRESPS);
        end
        n_vec++;
        if (req !== 1'b0) begin
            n_err++;
            $display("FAIL reset_req got=%b exp=0", req);
        end
        n_vec++;
        if (HTRANSM !== 2'b00 || HSELM !== 1'b0) begin
            n_err++;
            $display("FAIL reset_idle got trans=%b sel=%b exp 00/0",
                     HTRANSM, HSELM);
        end
        e.addr = '0;
        if (sb_q.size() != 0) sb_q.delete();
    endtask

    task automatic test_immediate_grant();
        exp_t e;
        active_trans = 1'b1;
        HREADYM = 1'b1;
        master_drive(32'h4000_0000, 2'b10, 3'b000, 1'b0);
        push_exp(32'h4000_0000, 2'b10, 3'b000, 1'b0);
        #1;
        n_vec++;
        if (req !== 1'b1) begin
            n_err++;
            $display("FAIL imm_req got=%b exp=1", req);
        end
        e = sb_q.pop_front();
        n_vec++;
        if (HADDRM !== e.addr || HTRANSM !== e.trans) begin
            n_err++;
            $display("FAIL imm_addr got=%h/%b exp=%h/%b",
                     HADDRM, HTRANSM, e.addr, e.trans);
        end
        step();
        master_idle();
        #1;
        n_vec++;
        if (HREADYOUTS !== 1'b1 || req !== 1'b0) begin
            n_err++;
            $display("FAIL imm_dphase got rdy=%b req=%b exp 1/0",
                     HREADYOUTS, req);
        end
        step();
    endtask

    task automatic test_stall_replay();
        exp_t e;
        bit   issued;
        active_trans = 1'b0;
        HREADYM = 1'b1;
        master_drive(32'h2000_0010, 2'b10, 3'b000, 1'b1);
        push_exp(32'h2000_0010, 2'b10, 3'b000, 1'b1);
        #1;
        n_vec++;
        if (req !== 1'b1) begin
            n_err++;
            $display("FAIL stall_req got=%b exp=1", req);
        end
        step();
        master_idle();
        HREADYS = 1'b0;
        HADDRS = 32'hDEAD_BEE0;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_vec++;
            if (HREADYOUTS !== 1'b0 || req !== 1'b1) begin
                n_err++;
                $display("FAIL stall_hold%0d got rdy=%b req=%b exp 0/1",
                         i, HREADYOUTS, req);
            end
            step();
        end
        active_trans = 1'b1;
        issued = 1'b0;
        for (int i = 0; i < 8 && !issued; i++) begin
            #1;
            if (req === 1'b1 && HTRANSM === 2'b10) begin
                issued = 1'b1;
                e = sb_q.pop_front();
                n_vec++;
                if (HADDRM !== e.addr || HWRITEM !== e.write) begin
                    n_err++;
                    $display("FAIL stall_issue got=%h/%b exp=%h/%b",
                             HADDRM, HWRITEM, e.addr, e.write);
                end
            end
            step();
        end
        if (!issued) begin
            n_vec++;
            n_err++;
            $display("FAIL stall_timeout got=none exp=issue");
            sb_q.delete();
        end
        active_trans = 1'b0;
        HREADYS = 1'b1;
        HREADYM = 1'b0;
        #1;
        n_vec++;
        if (HREADYOUTS !== 1'b0 || req !== 1'b0) begin
            n_err++;
            $display("FAIL stall_follow0 got rdy=%b req=%b exp 0/0",
                     HREADYOUTS, req);
        end
        HREADYM = 1'b1;
        #1;
        n_vec++;
        if (HREADYOUTS !== 1'b1) begin
            n_err++;
            $display("FAIL stall_follow1 got=%b exp=1", HREADYOUTS);
        end
        step();
    endtask

    task automatic test_broken_burst();
        exp_t e;
        active_trans = 1'b0;
        HREADYM = 1'b1;
        master_drive(32'h0000_100C, 2'b11, 3'b011, 1'b0);
        push_exp(32'h0000_100C, 2'b10, 3'b001, 1'b0);
        step();
        master_idle();
        HREADYS = 1'b0;
        active_trans = 1'b1;
        #1;
        e = sb_q.pop_front();
        n_vec++;
        if (HADDRM !== e.addr || HTRANSM !== e.trans || HBURSTM !== e.burst) begin
            n_err++;
            $display("FAIL burst_rewrite got=%h/%b/%b exp=%h/%b/%b",
                     HADDRM, HTRANSM, HBURSTM, e.addr, e.trans, e.burst);
        end
        step();
        HREADYS = 1'b1;
        step();
    endtask

    task automatic test_wait_error();
        logic [1:0] r;
        logic [1:0] stim [4];
        stim[0] = 2'b00;
        stim[1] = 2'b00;
        stim[2] = 2'b01;
        stim[3] = 2'b11;
        active_trans = 1'b1;
        HREADYM = 1'b1;
        HRESPM = 1'b0;
        master_drive(32'h3000_0000, 2'b10, 3'b000, 1'b0);
        rsp_q.push_back(2'b00);
        rsp_q.push_back(2'b00);
        rsp_q.push_back(2'b01);
        rsp_q.push_back(2'b11);
        step();
        master_idle();
        for (int i = 0; i < 4; i++) begin
            HREADYM = stim[i][1];
            HRESPM  = stim[i][0];
            #1;
            r = rsp_q.pop_front();
            n_vec++;
            if (HREADYOUTS !== r[1] || HRESPS !== r[0]) begin
                n_err++;
                $display("FAIL err_cycle%0d got rdy=%b resp=%b exp %b/%b",
                         i, HREADYOUTS, HRESPS, r[1], r[0]);
            end
            step();
        end
        HREADYM = 1'b1;
        HRESPM = 1'b0;
        step();
    endtask

    task automatic test_flush();
        exp_t e;
        active_trans = 1'b1;
        HREADYM = 1'b1;
        HRESPM = 1'b0;
        master_drive(32'h5000_0000, 2'b10, 3'b000, 1'b0);
        push_exp(32'h5000_0000, 2'b10, 3'b000, 1'b0);
        #1;
        e = sb_q.pop_front();
        n_vec++;
        if (HADDRM !== e.addr) begin
            n_err++;
            $display("FAIL flush_first got=%h exp=%h", HADDRM, e.addr);
        end
        step();
        active_trans = 1'b0;
        HREADYM = 1'b0;
        master_drive(32'h5000_0100, 2'b10, 3'b000, 1'b1);
`ifndef AHB_INSTG_ERR_FLUSH_EN
        push_exp(32'h5000_0100, 2'b10, 3'b000, 1'b1);
`endif
        step();
        master_idle();
        HREADYS = 1'b0;
        HRESPM = 1'b1;
        #1;
        n_vec++;
        if (HRESPS !== 1'b1 || HREADYOUTS !== 1'b0) begin
            n_err++;
            $display("FAIL flush_err1 got rdy=%b resp=%b exp 0/1",
                     HREADYOUTS, HRESPS);
        end
        step();
        HREADYM = 1'b1;
        #1;
        n_vec++;
`ifdef AHB_INSTG_ERR_FLUSH_EN
        if (req !== 1'b0) begin
            n_err++;
            $display("FAIL flush_req got=%b exp=0", req);
        end
`else
        if (req !== 1'b1) begin
            n_err++;
            $display("FAIL flush_keep got=%b exp=1", req);
        end
`endif
        step();
        HRESPM = 1'b0;
        HREADYS = 1'b1;
        active_trans = 1'b1;
        #1;
        n_vec++;
`ifdef AHB_INSTG_ERR_FLUSH_EN
        if (HTRANSM !== 2'b00 || req !== 1'b0) begin
            n_err++;
            $display("FAIL flush_noissue got=%b/%b exp 00/0", HTRANSM, req);
        end
`else
        e = sb_q.pop_front();
        if (HTRANSM !== e.trans || HADDRM !== e.addr || HWRITEM !== e.write) begin
            n_err++;
            $display("FAIL flush_issue got=%h/%b exp=%h/%b",
                     HADDRM, HTRANSM, e.addr, e.trans);
        end
`endif
        step();
        step();
    endtask

    task automatic test_reset_mid();
        active_trans = 1'b0;
        HREADYM = 1'b1;
        master_drive(32'h6000_0000, 2'b10, 3'b000, 1'b0);
        step();
        master_idle();
        HREADYS = 1'b0;
        HRESET = 1'b1;
        step();
        HRESET = 1'b0;
        HREADYS = 1'b1;
        #1;
        n_vec++;
        if (HREADYOUTS !== 1'b1 || req !== 1'b0 || HTRANSM !== 2'b00) begin
            n_err++;
            $display("FAIL rstmid_state got rdy=%b req=%b tr=%b exp 1/0/00",
                     HREADYOUTS, req, HTRANSM);
        end
        active_trans = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            n_vec++;
            if (HTRANSM !== 2'b00 || req !== 1'b0) begin
                n_err++;
                $display("FAIL rstmid_replay%0d got tr=%b req=%b exp 00/0",
                         i, HTRANSM, req);
            end
        end
    endtask

    task automatic test_back_to_back();
        exp_t       e;
        logic [1:0] tr [5];
        tr[0] = 2'b10;
        tr[1] = 2'b11;
        tr[2] = 2'b01;
        tr[3] = 2'b11;
        tr[4] = 2'b11;
        active_trans = 1'b1;
        HREADYM = 1'b1;
        for (int i = 0; i < 5; i++) begin
            master_drive(32'h7000_0000 + 32'(4 * (i > 2 ? i - 1 : i)),
                         tr[i], 3'b011, 1'b1);
            if (tr[i] != 2'b01)
                push_exp(HADDRS, tr[i], 3'b011, 1'b1);
            #1;
            n_vec++;
            if (tr[i] == 2'b01) begin
                if (req !== 1'b0) begin
                    n_err++;
                    $display("FAIL b2b_busy got req=%b exp=0", req);
                end
            end else begin
                e = sb_q.pop_front();
                if (HADDRM !== e.addr || HTRANSM !== e.trans ||
                    HBURSTM !== e.burst || req !== 1'b1) begin
                    n_err++;
                    $display("FAIL b2b_beat%0d got=%h/%b/%b exp=%h/%b/%b",
                             i, HADDRM, HTRANSM, HBURSTM,
                             e.addr, e.trans, e.burst);
                end
            end
            if (i > 0) begin
                n_vec++;
                if (HREADYOUTS !== 1'b1) begin
                    n_err++;
                    $display("FAIL b2b_ready%0d got=%b exp=1", i, HREADYOUTS);
                end
            end
            step();
        end
        master_idle();
        step();
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        HRESET = 1'b1;
        active_trans = 1'b0;
        HREADYM = 1'b1;
        HRESPM = 1'b0;
        master_idle();
        test_reset();
        test_immediate_grant();
        test_stall_replay();
        test_broken_burst();
        test_wait_error();
        test_flush();
        test_reset_mid();
        test_back_to_back();
        if (sb_q.size() != 0 || rsp_q.size() != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL sb_leftover got=%0d/%0d exp=0/0",
                     sb_q.size(), rsp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
